framebuffer_port_arbiter: RTL

- Shares the single-port framebuffer RAM between two requesters: the display fetch path, which issues reads, and the host loader path, which issues writes.
- Display reads have strict priority and a fixed latency, so scan timing is never disturbed.
- Host writes are buffered in a small FIFO and drained on cycles with no read.
- Sits between framebuffer_fetch / the host loader and the framebuffer RAM primitive.

---
 rtl/framebuffer_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/framebuffer_port_arbiter.sv
// Arbitrates the single-port framebuffer RAM between display reads and host writes.
// Reads always take the port. Host writes wait in a small FIFO and use cycles that have no read.
module framebuffer_port_arbiter #(
  parameter int PIXEL_WIDTH      = 64,
  parameter int PIXEL_HALFHEIGHT = 16,
  parameter int BYTES_PER_PIXEL  = 2,
  parameter int WR_FIFO_DEPTH    = 4,
  parameter int STARVE_LIMIT     = 64,
  localparam int AW = $clog2(PIXEL_WIDTH) + $clog2(PIXEL_HALFHEIGHT) + 1,
  localparam int DW = BYTES_PER_PIXEL * 8,
  localparam int CW = $clog2(WR_FIFO_DEPTH) + 1
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic [CW-1:0] wr_fifo_count,
  output logic          wr_starved,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_out,
  output logic          ram_write_enable,
  output logic          ram_clk_enable,
  input  logic [DW-1:0] ram_data_in
);

  localparam int PW = $clog2(WR_FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0] fifo_addr [WR_FIFO_DEPTH];
  logic [DW-1:0] fifo_data [WR_FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic [SW-1:0] starve_next;
  logic          rd_stage;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign fifo_empty    = (count == '0);
  assign wr_ready      = (count < CW'(WR_FIFO_DEPTH));
  assign wr_fifo_count = count;
  assign push          = wr_valid & wr_ready;
  assign pop           = ~rd_req & ~fifo_empty;

  always_comb begin
    starve_next = '0;
    if (rd_req && !fifo_empty)
      starve_next = (starve == SW'(STARVE_LIMIT)) ? starve : starve + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_addr[tail] <= wr_addr;
      fifo_data[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      starve           <= '0;
      wr_starved       <= 1'b0;
      rd_stage         <= 1'b0;
      rd_valid         <= 1'b0;
      rd_data          <= '0;
      ram_address      <= '0;
      ram_data_out     <= '0;
      ram_write_enable <= 1'b0;
      ram_clk_enable   <= 1'b0;
    end else begin
      // The registered RAM controls are the first read stage. A granted read
      // shows up as clk_enable high with write_enable low.
      rd_stage <= ram_clk_enable & ~ram_write_enable;
      rd_valid <= rd_stage;
      if (rd_stage)
        rd_data <= ram_data_in;

      if (rd_req) begin
        ram_address      <= rd_addr;
        ram_write_enable <= 1'b0;
        ram_clk_enable   <= 1'b1;
      end else if (pop) begin
        ram_address      <= fifo_addr[head];
        ram_data_out     <= fifo_data[head];
        ram_write_enable <= 1'b1;
        ram_clk_enable   <= 1'b1;
        head             <= head + 1'b1;
      end else begin
        ram_write_enable <= 1'b0;
        ram_clk_enable   <= 1'b0;
      end

      if (push)
        tail <= tail + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      starve     <= starve_next;
      wr_starved <= (starve_next == SW'(STARVE_LIMIT));
    end
  end

endmodule
